// File: rtl/params_pkg.sv
// Project-wide widths shared by the ROB and the blocks that feed it.
package params_pkg;
    parameter int ROB_ENTRY_WIDTH = 6;
    parameter int DATA_WIDTH      = 32;
endpackage

// File: rtl/rob_complete_arbiter.sv
// Buffers completions from several execute units and serialises them round-robin onto the ROB completion port.
// Optional per-source stall/grant counters are built when COMPLETE_ARB_STATS_EN is defined.
module rob_complete_arbiter #(
    parameter int NUM_SRC         = 3,
    parameter int FIFO_DEPTH      = 2,
    parameter int ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
    parameter int DATA_WIDTH      = params_pkg::DATA_WIDTH
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_i,
    input  logic [NUM_SRC-1:0]                        src_valid_i,
    output logic [NUM_SRC-1:0]                        src_ready_o,
    input  logic [NUM_SRC-1:0][ROB_ENTRY_WIDTH-1:0]   src_idx_i,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]        src_data_i,
    input  logic [NUM_SRC-1:0]                        src_excp_i,
    output logic                                      complete_valid_o,
    output logic [ROB_ENTRY_WIDTH-1:0]                complete_idx_o,
    output logic [DATA_WIDTH-1:0]                     complete_data_o,
    output logic                                      complete_excp_o
`ifdef COMPLETE_ARB_STATS_EN
    ,
    output logic [NUM_SRC-1:0][31:0]                  stall_cnt_o,
    output logic [NUM_SRC-1:0][31:0]                  grant_cnt_o
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RR_W  = $clog2(NUM_SRC);
    localparam int ENT_W = ROB_ENTRY_WIDTH + DATA_WIDTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(NUM_SRC - 1);
    localparam logic [RR_W-1:0]  RR_ONE   = RR_W'(1);

    logic [ENT_W-1:0]                 mem_q [NUM_SRC][FIFO_DEPTH];
    logic [NUM_SRC-1:0][CNT_W-1:0]    count_q, count_d;
    logic [NUM_SRC-1:0][PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [NUM_SRC-1:0][PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [RR_W-1:0]                  rr_q, rr_d;
    logic                             valid_q, valid_d;
    logic [ROB_ENTRY_WIDTH-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]            data_q, data_d;
    logic                             excp_q, excp_d;

    logic [NUM_SRC-1:0]               push;
    logic [NUM_SRC-1:0]               pop;
    logic                             grant;
    logic [RR_W-1:0]                  winner;
    logic [ENT_W-1:0]                 head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // No pass-through: readiness looks only at registered occupancy.
    always_comb begin
        src_ready_o = '0;
        push        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_ready_o[k] = (count_q[k] < DEPTH_C) && !flush_i;
            push[k]        = src_valid_i[k] && src_ready_o[k];
        end
    end

    always_comb begin
        int c;
        grant  = 1'b0;
        winner = rr_q;
        c      = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            c = int'(rr_q) + i;
            if (c >= NUM_SRC) begin
                c = c - NUM_SRC;
            end
            if (!grant && !flush_i && (count_q[c] != '0)) begin
                grant  = 1'b1;
                winner = RR_W'(c);
            end
        end
        pop = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pop[k] = grant && (winner == RR_W'(k));
        end
        head = mem_q[winner][rd_ptr_q[winner]];
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_d     = rr_q;
        valid_d  = grant;
        idx_d    = idx_q;
        data_d   = data_q;
        excp_d   = excp_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (push[k]) begin
                    wr_ptr_d[k] = ptr_inc(wr_ptr_q[k]);
                end
                if (pop[k]) begin
                    rd_ptr_d[k] = ptr_inc(rd_ptr_q[k]);
                end
                if (push[k] && !pop[k]) begin
                    count_d[k] = count_q[k] + CNT_ONE;
                end else if (!push[k] && pop[k]) begin
                    count_d[k] = count_q[k] - CNT_ONE;
                end
            end
            if (grant) begin
                rr_d   = (winner == RR_LAST) ? '0 : winner + RR_ONE;
                idx_d  = head[ENT_W-1 -: ROB_ENTRY_WIDTH];
                data_d = head[DATA_WIDTH:1];
                excp_d = head[0];
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= {src_idx_i[k], src_data_i[k], src_excp_i[k]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_q     <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
            excp_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_q     <= rr_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            excp_q   <= excp_d;
        end
    end

    assign complete_valid_o = valid_q;
    assign complete_idx_o   = idx_q;
    assign complete_data_o  = data_q;
    assign complete_excp_o  = excp_q;

`ifdef COMPLETE_ARB_STATS_EN
    logic [NUM_SRC-1:0][31:0] stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC-1:0][31:0] grant_cnt_q, grant_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        grant_cnt_d = grant_cnt_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_valid_i[k] && !src_ready_o[k]) begin
                stall_cnt_d[k] = sat_inc(stall_cnt_q[k]);
            end
            if (pop[k]) begin
                grant_cnt_d[k] = sat_inc(grant_cnt_q[k]);
            end
        end
    end

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign grant_cnt_o = grant_cnt_q;
`endif
endmodule
